// File: rtl/seq_mul32.sv
// Iterative 32x32->64 shift-add multiplier driving one cla32 per cycle, valid/ready on both sides.
// Define MUL_SIGNED_EN to add the i_op_signed port and two's-complement operand support.
module cla32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  // 4-bit lookahead groups, group carries rippled between groups
  always_comb begin
    w_g    = i_a & i_b;
    w_p    = i_a ^ i_b;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < 8; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
    o_sum  = w_p ^ w_c[31:0];
    o_cout = w_c[32];
  end

endmodule

module seq_mul32 #(
  parameter int unsigned EARLY_ZERO = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
`ifdef MUL_SIGNED_EN
  input  logic        i_op_signed,
`endif
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_product,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_count;

  logic        w_accept;
  logic        w_zero_op;
  logic        w_last;
  logic        w_signed;
  logic        w_sub;
  logic [31:0] w_num2;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_new_top;

`ifdef MUL_SIGNED_EN
  logic r_signed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= i_op_signed;
    end
  end

  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif

  assign w_accept  = i_in_valid && (r_state == StIdle);
  assign w_zero_op = (EARLY_ZERO != 0) && ((i_op_a == '0) || (i_op_b == '0));
  assign w_last    = (r_count == 5'd31);
  // Signed multiplier MSB carries weight -2^31, so the final iteration subtracts mcand
  assign w_sub     = w_signed && w_last;
  assign w_num2    = r_lo[0] ? (w_sub ? ~r_mcand : r_mcand) : '0;
  assign w_cin     = r_lo[0] & w_sub;

  cla32 u_cla (
    .i_a    (r_hi),
    .i_b    (w_num2),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Signed: 33rd bit of the sign-extended sum; unsigned: plain carry-out
  assign w_new_top = w_signed ? (r_hi[31] ^ w_num2[31] ^ w_cout) : (r_lo[0] & w_cout);

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    o_product   = '0;
    unique case (r_state)
      StIdle: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (w_accept) begin
          w_state_nxt = w_zero_op ? StDone : StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_out_valid = 1'b1;
        o_product   = {r_hi, r_lo};
        if (i_out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_mcand <= i_op_a;
      r_hi    <= '0;
      r_lo    <= w_zero_op ? '0 : i_op_b;
      r_count <= '0;
    end else if (r_state == StRun) begin
      {r_hi, r_lo} <= {w_new_top, w_sum, r_lo[31:1]};
      r_count      <= r_count + 5'd1;
    end
  end

endmodule

// File: tb/tb_seq_mul32.sv
// Directed self-checking bench for seq_mul32; second instance built with EARLY_ZERO=1.
// Latency is counted in clock edges after the accepting edge.
module tb_seq_mul32;

  logic        clk;
  logic        rst_n;
  logic        in_valid, out_ready, in_ready, out_valid, busy;
  logic [31:0] op_a, op_b;
  logic [63:0] product;
  logic        ez_in_valid, ez_out_ready, ez_in_ready, ez_out_valid, ez_busy;
  logic [31:0] ez_op_a, ez_op_b;
  logic [63:0] ez_product;
`ifdef MUL_SIGNED_EN
  logic        op_signed, ez_op_signed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul32 #(.EARLY_ZERO(0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
`ifdef MUL_SIGNED_EN
    .i_op_signed (op_signed),
`endif
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_product   (product),
    .o_busy      (busy)
  );

  seq_mul32 #(.EARLY_ZERO(1)) dut_ez (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (ez_in_valid),
    .o_in_ready  (ez_in_ready),
    .i_op_a      (ez_op_a),
    .i_op_b      (ez_op_b),
`ifdef MUL_SIGNED_EN
    .i_op_signed (ez_op_signed),
`endif
    .o_out_valid (ez_out_valid),
    .i_out_ready (ez_out_ready),
    .o_product   (ez_product),
    .o_busy      (ez_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures",
             n_checks, n_fail);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait for the product; lat = edges after the accepting edge
  task automatic run_op(input bit ez, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat);
    int guard = 0;
    while (((ez ? ez_in_ready : in_ready) !== 1'b1) && guard < 100) begin
      step();
      guard++;
    end
    if (ez) begin ez_in_valid = 1'b1; ez_op_a = a; ez_op_b = b; end
    else    begin in_valid    = 1'b1; op_a    = a; op_b    = b; end
    step();
    if (ez) begin ez_in_valid = 1'b0; ez_op_a = 32'hDEAD_BEEF; ez_op_b = 32'h0BAD_F00D; end
    else    begin in_valid    = 1'b0; op_a    = 32'hDEAD_BEEF; op_b    = 32'h0BAD_F00D; end
    lat = 0;
    while (((ez ? ez_out_valid : out_valid) !== 1'b1) && lat < 100) begin
      step();
      lat++;
    end
    p = ez ? ez_product : product;
  endtask

  task automatic take(input bit ez);
    if (ez) ez_out_ready = 1'b1; else out_ready = 1'b1;
    step();
    if (ez) ez_out_ready = 1'b0; else out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    ez_in_valid = 1'b0; ez_out_ready = 1'b0; ez_op_a = '0; ez_op_b = '0;
`ifdef MUL_SIGNED_EN
    op_signed = 1'b0; ez_op_signed = 1'b0;
`endif
    step();
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (product !== 64'h0) begin n_fail++; $display("FAIL reset_product: got %h want 0", product); end
    n_checks++;
    if (ez_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ez_in_ready: got %b want 1", ez_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_max_unsigned();
    logic [63:0] p;
    int lat;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
    n_checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL max_product: got %h want fffffffe00000001", p); end
    n_checks++;
    if (lat !== 32) begin n_fail++; $display("FAIL max_latency: got %0d want 32", lat); end
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL max_done_flags: got in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    take(1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL max_after_take: got out_valid=%b in_ready=%b busy=%b want 0/1/0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p;
    int lat;
    run_op(1'b0, 32'd7, 32'd6, p, lat);
    n_checks++;
    if (p !== 64'h2A) begin n_fail++; $display("FAIL bp_product: got %h want 2a", p); end
    for (int i = 0; i < 5; i++) begin
      // New request while DONE must be ignored
      in_valid = 1'b1; op_a = 32'd9; op_b = 32'd9;
      step();
      n_checks++;
      if (product !== 64'h2A || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got product=%h out_valid=%b in_ready=%b busy=%b want 2a/1/0/1",
                 i, product, out_valid, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    take(1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    step();
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_stays_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] p;
    int lat;
    in_valid = 1'b1; op_a = 32'h1234; op_b = 32'h5678;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got out_valid=%b in_ready=%b busy=%b want 0/1/0",
               out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, p, lat);
    n_checks++;
    if (p !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL midrun_next_product: got %h want 100000000", p); end
    n_checks++;
    if (lat !== 32) begin n_fail++; $display("FAIL midrun_next_latency: got %0d want 32", lat); end
    take(1'b0);
  endtask

  task automatic test_early_zero();
    logic [63:0] p;
    int lat;
    run_op(1'b1, 32'h0, 32'h1234, p, lat);
    n_checks++;
    if (p !== 64'h0 || lat !== 0) begin n_fail++; $display("FAIL ez_a_zero: got p=%h lat=%0d want 0/0", p, lat); end
    take(1'b1);
    run_op(1'b1, 32'hABCD, 32'h0, p, lat);
    n_checks++;
    if (p !== 64'h0 || lat !== 0) begin n_fail++; $display("FAIL ez_b_zero: got p=%h lat=%0d want 0/0", p, lat); end
    take(1'b1);
    run_op(1'b1, 32'd3, 32'd5, p, lat);
    n_checks++;
    if (p !== 64'd15 || lat !== 32) begin n_fail++; $display("FAIL ez_nonzero: got p=%h lat=%0d want f/32", p, lat); end
    take(1'b1);
    run_op(1'b0, 32'h0, 32'h1234, p, lat);
    n_checks++;
    if (p !== 64'h0 || lat !== 32) begin n_fail++; $display("FAIL noez_zero: got p=%h lat=%0d want 0/32", p, lat); end
    take(1'b0);
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    logic [63:0] p;
    int lat;
    op_signed = 1'b1;
    run_op(1'b0, 32'hFFFF_FFFB, 32'd3, p, lat);
    n_checks++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFF1 || lat !== 32) begin
      n_fail++; $display("FAIL signed_m5x3: got p=%h lat=%0d want fffffffffffffff1/32", p, lat);
    end
    take(1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, p, lat);
    n_checks++;
    if (p !== 64'h4000_0000_0000_0000) begin
      n_fail++; $display("FAIL signed_minxmin: got %h want 4000000000000000", p);
    end
    take(1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
    n_checks++;
    if (p !== 64'h1) begin n_fail++; $display("FAIL signed_m1xm1: got %h want 1", p); end
    take(1'b0);
    op_signed = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] exp_p;
    int steps;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      exp_p = {32'b0, a} * {32'b0, b};
      op_a = a;
      op_b = b;
      step();
      steps = 1;
      op_a = $urandom;
      op_b = $urandom;
      while (out_valid !== 1'b1 && steps < 100) begin
        step();
        steps++;
      end
      n_checks++;
      if (product !== exp_p) begin
        n_fail++; $display("FAIL b2b_product_%0d: %h*%h got %h want %h", n, a, b, product, exp_p);
      end
      step();
      steps++;
      n_checks++;
      if (steps !== 34 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_period_%0d: got %0d clocks in_ready=%b want 34/1", n, steps, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_max_unsigned();
    test_backpressure();
    test_reset_mid_run();
    test_early_zero();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
